// File: rtl/nmp_wrapper.sv
// AXI4-Lite near-memory processor: two operand arrays A and B. A read of a
// low address returns A[k]+B[k]; a read of a high address returns raw B.
`timescale 1ns/1ps

module nmp_wrapper #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_SIZE   = 256
) (
  input  logic                    ACLK,
  input  logic                    ARESETN,
  // write address / data / response
  input  logic [ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic                    S_AXI_AWVALID,
  output logic                    S_AXI_AWREADY,
  input  logic [DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                    S_AXI_WVALID,
  output logic                    S_AXI_WREADY,
  output logic [1:0]              S_AXI_BRESP,
  output logic                    S_AXI_BVALID,
  input  logic                    S_AXI_BREADY,
  // read address / data
  input  logic [ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic                    S_AXI_ARVALID,
  output logic                    S_AXI_ARREADY,
  output logic [DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]              S_AXI_RRESP,
  output logic                    S_AXI_RVALID,
  input  logic                    S_AXI_RREADY
);

  localparam int HALF   = MEM_SIZE / 2;
  localparam int IDX_W  = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int STRB_W = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH-1:0] HALF_ADDR = ADDR_WIDTH'(HALF);

  typedef enum logic {
    W_IDLE,
    W_RESP
  } w_state_t;

  typedef enum logic [1:0] {
    R_IDLE,
    R_FETCH,
    R_RESP
  } r_state_t;

  // Ready outputs stay low until the first edge after reset release.
  logic out_en;

  // NOTE: every clocked register below uses non-blocking (<=) assignments so
  // all flops sample the same pre-edge values regardless of process order.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) out_en <= 1'b0;
    else          out_en <= 1'b1;
  end

  assign S_AXI_BRESP = 2'b00;
  assign S_AXI_RRESP = 2'b00;

  // ---------------------------------------------------------------- write path
  w_state_t w_state, w_state_nxt;
  logic     w_accept;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) w_state <= W_IDLE;
    else          w_state <= w_state_nxt;
  end

  // NOTE: each combinational output gets a default before the case statement,
  // so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt   = w_state;
    S_AXI_AWREADY = 1'b0;
    S_AXI_WREADY  = 1'b0;
    S_AXI_BVALID  = 1'b0;
    w_accept      = 1'b0;
    case (w_state)
      W_IDLE: begin
        S_AXI_AWREADY = out_en;
        S_AXI_WREADY  = out_en;
        if (out_en && S_AXI_AWVALID && S_AXI_WVALID) begin
          w_accept    = 1'b1;
          w_state_nxt = W_RESP;
        end
      end
      W_RESP: begin
        S_AXI_BVALID = 1'b1;
        if (S_AXI_BREADY) w_state_nxt = W_IDLE;
      end
    endcase
  end

  logic             w_in_b;
  logic [IDX_W-1:0] w_idx;

  assign w_in_b = (S_AXI_AWADDR >= HALF_ADDR);
  assign w_idx  = w_in_b ? IDX_W'(S_AXI_AWADDR - HALF_ADDR) : IDX_W'(S_AXI_AWADDR);

  logic [DATA_WIDTH-1:0] mem_a [HALF];
  logic [DATA_WIDTH-1:0] mem_b [HALF];

  // NOTE: the operand arrays have no reset; their contents must survive a
  // reset pulse, and leaving storage unreset lets it map onto RAM.
  always_ff @(posedge ACLK) begin
    if (w_accept) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (S_AXI_WSTRB[i]) begin
          if (w_in_b) mem_b[w_idx][i*8 +: 8] <= S_AXI_WDATA[i*8 +: 8];
          else        mem_a[w_idx][i*8 +: 8] <= S_AXI_WDATA[i*8 +: 8];
        end
      end
    end
  end

  // ----------------------------------------------------------------- read path
  r_state_t              r_state, r_state_nxt;
  logic                  ar_accept;
  logic [ADDR_WIDTH-1:0] ar_addr_q;
  logic                  r_in_b;
  logic [IDX_W-1:0]      r_idx;
  logic [DATA_WIDTH-1:0] fetch_data;

  always_comb begin
    r_state_nxt   = r_state;
    S_AXI_ARREADY = 1'b0;
    S_AXI_RVALID  = 1'b0;
    ar_accept     = 1'b0;
    case (r_state)
      R_IDLE: begin
        S_AXI_ARREADY = out_en;
        if (out_en && S_AXI_ARVALID) begin
          ar_accept   = 1'b1;
          r_state_nxt = R_FETCH;
        end
      end
      R_FETCH: r_state_nxt = R_RESP;
      R_RESP: begin
        S_AXI_RVALID = 1'b1;
        if (S_AXI_RREADY) r_state_nxt = R_IDLE;
      end
      default: r_state_nxt = R_IDLE;
    endcase
  end

  assign r_in_b = (ar_addr_q >= HALF_ADDR);
  assign r_idx  = r_in_b ? IDX_W'(ar_addr_q - HALF_ADDR) : IDX_W'(ar_addr_q);

  // Sampled at the fetch edge, so a write landing on that same edge is not seen.
  assign fetch_data = r_in_b ? mem_b[r_idx] : (mem_a[r_idx] + mem_b[r_idx]);

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_state     <= R_IDLE;
      ar_addr_q   <= '0;
      S_AXI_RDATA <= '0;
    end else begin
      r_state <= r_state_nxt;
      if (ar_accept)          ar_addr_q   <= S_AXI_ARADDR;
      if (r_state == R_FETCH) S_AXI_RDATA <= fetch_data;
    end
  end

endmodule

// File: tb/tb_nmp_wrapper.sv
// Randomized self-checking bench for nmp_wrapper against a flat-memory model
// in which addresses 0..HALF-1 hold A and HALF..MS-1 hold B.
`timescale 1ns/1ps

module tb_nmp_wrapper;

  localparam int AW   = 8;
  localparam int DW   = 32;
  localparam int MS   = 256;
  localparam int HALF = MS / 2;

  logic          ACLK = 1'b0;
  logic          ARESETN = 1'b0;
  logic [AW-1:0] S_AXI_AWADDR = '0;
  logic          S_AXI_AWVALID = 1'b0;
  logic          S_AXI_AWREADY;
  logic [DW-1:0] S_AXI_WDATA = '0;
  logic [3:0]    S_AXI_WSTRB = '0;
  logic          S_AXI_WVALID = 1'b0;
  logic          S_AXI_WREADY;
  logic [1:0]    S_AXI_BRESP;
  logic          S_AXI_BVALID;
  logic          S_AXI_BREADY = 1'b0;
  logic [AW-1:0] S_AXI_ARADDR = '0;
  logic          S_AXI_ARVALID = 1'b0;
  logic          S_AXI_ARREADY;
  logic [DW-1:0] S_AXI_RDATA;
  logic [1:0]    S_AXI_RRESP;
  logic          S_AXI_RVALID;
  logic          S_AXI_RREADY = 1'b0;

  nmp_wrapper #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_SIZE(MS)) dut (
    .ACLK          (ACLK),
    .ARESETN       (ARESETN),
    .S_AXI_AWADDR  (S_AXI_AWADDR),
    .S_AXI_AWVALID (S_AXI_AWVALID),
    .S_AXI_AWREADY (S_AXI_AWREADY),
    .S_AXI_WDATA   (S_AXI_WDATA),
    .S_AXI_WSTRB   (S_AXI_WSTRB),
    .S_AXI_WVALID  (S_AXI_WVALID),
    .S_AXI_WREADY  (S_AXI_WREADY),
    .S_AXI_BRESP   (S_AXI_BRESP),
    .S_AXI_BVALID  (S_AXI_BVALID),
    .S_AXI_BREADY  (S_AXI_BREADY),
    .S_AXI_ARADDR  (S_AXI_ARADDR),
    .S_AXI_ARVALID (S_AXI_ARVALID),
    .S_AXI_ARREADY (S_AXI_ARREADY),
    .S_AXI_RDATA   (S_AXI_RDATA),
    .S_AXI_RRESP   (S_AXI_RRESP),
    .S_AXI_RVALID  (S_AXI_RVALID),
    .S_AXI_RREADY  (S_AXI_RREADY)
  );

  always #5 ACLK = ~ACLK;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] ref_mem [MS];

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%08h exp=0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] model_read(input int k);
    logic [DW-1:0] s;
    if (k < HALF) s = ref_mem[k] + ref_mem[k + HALF];
    else          s = ref_mem[k];
    return s;
  endfunction

  function automatic void model_write(input int addr, input logic [DW-1:0] data,
                                      input logic [3:0] strb);
    for (int i = 0; i < 4; i++)
      if (strb[i]) ref_mem[addr][i*8 +: 8] = data[i*8 +: 8];
  endfunction

  task automatic axi_write(input int addr, input logic [DW-1:0] data,
                           input logic [3:0] strb, input int hold);
    int n;
    @(negedge ACLK);
    S_AXI_AWADDR  = AW'(addr);
    S_AXI_WDATA   = data;
    S_AXI_WSTRB   = strb;
    S_AXI_AWVALID = 1'b1;
    S_AXI_WVALID  = 1'b1;
    S_AXI_BREADY  = (hold == 0);
    n = 0;
    while (!(S_AXI_AWREADY && S_AXI_WREADY) && n < 20) begin
      @(negedge ACLK);
      n++;
    end
    check("aw_ready", 32'(S_AXI_AWREADY && S_AXI_WREADY), 32'd1);
    @(posedge ACLK);
    model_write(addr, data, strb);
    @(negedge ACLK);
    S_AXI_AWVALID = 1'b0;
    S_AXI_WVALID  = 1'b0;
    n = 1;
    while (!S_AXI_BVALID && n < 20) begin
      @(negedge ACLK);
      n++;
    end
    check("b_latency", 32'(n), 32'd1);
    check("bresp", 32'(S_AXI_BRESP), 32'd0);
    for (int i = 0; i < hold; i++) begin
      check("b_hold_valid", 32'(S_AXI_BVALID), 32'd1);
      check("b_hold_awready", 32'(S_AXI_AWREADY), 32'd0);
      @(negedge ACLK);
    end
    S_AXI_BREADY = 1'b1;
    @(negedge ACLK);
    check("b_done", 32'(S_AXI_BVALID), 32'd0);
    check("aw_ready_back", 32'(S_AXI_AWREADY), 32'd1);
  endtask

  task automatic axi_read(input int addr, input int hold, output logic [DW-1:0] data);
    int n;
    logic [DW-1:0] exp;
    @(negedge ACLK);
    S_AXI_ARADDR  = AW'(addr);
    S_AXI_ARVALID = 1'b1;
    S_AXI_RREADY  = (hold == 0);
    n = 0;
    while (!S_AXI_ARREADY && n < 20) begin
      @(negedge ACLK);
      n++;
    end
    check("ar_ready", 32'(S_AXI_ARREADY), 32'd1);
    @(posedge ACLK);
    exp = model_read(addr);
    @(negedge ACLK);
    S_AXI_ARVALID = 1'b0;
    n = 1;
    while (!S_AXI_RVALID && n < 20) begin
      @(negedge ACLK);
      n++;
    end
    check("r_latency", 32'(n), 32'd2);
    check("rresp", 32'(S_AXI_RRESP), 32'd0);
    check("rdata", S_AXI_RDATA, exp);
    data = S_AXI_RDATA;
    for (int i = 0; i < hold; i++) begin
      check("r_hold_valid", 32'(S_AXI_RVALID), 32'd1);
      check("r_hold_data", S_AXI_RDATA, exp);
      check("r_hold_arready", 32'(S_AXI_ARREADY), 32'd0);
      @(negedge ACLK);
    end
    S_AXI_RREADY = 1'b1;
    @(negedge ACLK);
    check("r_done", 32'(S_AXI_RVALID), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_awready"}, 32'(S_AXI_AWREADY), 32'd0);
    check({tag, "_wready"},  32'(S_AXI_WREADY),  32'd0);
    check({tag, "_arready"}, 32'(S_AXI_ARREADY), 32'd0);
    check({tag, "_bvalid"},  32'(S_AXI_BVALID),  32'd0);
    check({tag, "_rvalid"},  32'(S_AXI_RVALID),  32'd0);
    check({tag, "_rdata"},   S_AXI_RDATA,        32'd0);
    check({tag, "_resp"},    32'({S_AXI_BRESP, S_AXI_RRESP}), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] d;
    logic [DW-1:0] exp_old;
    logic [DW-1:0] new_word;

    repeat (3) @(negedge ACLK);
    check_reset_outputs("reset");
    ARESETN = 1'b1;
    @(negedge ACLK);
    check("post_rst_awready", 32'(S_AXI_AWREADY), 32'd1);
    check("post_rst_wready",  32'(S_AXI_WREADY),  32'd1);
    check("post_rst_arready", 32'(S_AXI_ARREADY), 32'd1);

    // Fill every word so the model is fully known.
    for (int a = 0; a < MS; a++) axi_write(a, $urandom, 4'hF, 0);

    // Element-wise add, 4x4 and 8x8 patterns (the latter covers the former).
    for (int k = 0; k < 64; k++) begin
      axi_write(k, DW'(k), 4'hF, 0);
      axi_write(HALF + k, DW'(2 * k), 4'hF, 0);
    end
    for (int k = 0; k < 64; k++) begin
      axi_read(k, 0, d);
      check("add_3k", d, DW'(3 * k));
    end

    // Carry out of the top bit is discarded.
    axi_write(5, 32'hFFFF_FFFF, 4'hF, 0);
    axi_write(HALF + 5, 32'd2, 4'hF, 0);
    axi_read(5, 0, d);
    check("overflow", d, 32'h0000_0001);

    // Byte strobes.
    axi_write(3, 32'h1122_3344, 4'hF, 0);
    axi_write(3, 32'hAABB_CCDD, 4'b0011, 0);
    axi_write(HALF + 3, 32'd0, 4'hF, 0);
    axi_read(3, 0, d);
    check("strobe_merge", d, 32'h1122_CCDD);
    axi_read(HALF + 3, 0, d);
    check("strobe_b_raw", d, 32'd0);

    // Zero strobe leaves memory untouched.
    axi_write(10, 32'hDEAD_BEEF, 4'b0000, 0);
    axi_read(10, 0, d);

    // Backpressure on both response channels.
    axi_write(20, $urandom, 4'hF, 5);
    axi_read(20, 5, d);
    axi_read(HALF + 20, 5, d);

    // Write committing on the read's fetch edge: read sees pre-write data.
    @(negedge ACLK);
    S_AXI_ARADDR  = AW'(7);
    S_AXI_ARVALID = 1'b1;
    S_AXI_RREADY  = 1'b0;
    S_AXI_BREADY  = 1'b0;
    exp_old = model_read(7);
    new_word = $urandom;
    @(negedge ACLK);
    S_AXI_ARVALID = 1'b0;
    S_AXI_AWADDR  = AW'(7);
    S_AXI_WDATA   = new_word;
    S_AXI_WSTRB   = 4'hF;
    S_AXI_AWVALID = 1'b1;
    S_AXI_WVALID  = 1'b1;
    @(negedge ACLK);
    S_AXI_AWVALID = 1'b0;
    S_AXI_WVALID  = 1'b0;
    model_write(7, new_word, 4'hF);
    check("same_cycle_bvalid", 32'(S_AXI_BVALID), 32'd1);
    check("same_cycle_rvalid", 32'(S_AXI_RVALID), 32'd1);
    check("same_cycle_old",    S_AXI_RDATA, exp_old);
    S_AXI_RREADY = 1'b1;
    S_AXI_BREADY = 1'b1;
    @(negedge ACLK);
    check("same_cycle_done", 32'({S_AXI_BVALID, S_AXI_RVALID}), 32'd0);
    axi_read(7, 0, d);

    // Random mix of writes and reads.
    for (int t = 0; t < 300; t++) begin
      if ($urandom_range(0, 1) == 0)
        axi_write(int'($urandom_range(0, MS - 1)), $urandom,
                  4'($urandom_range(0, 15)), int'($urandom_range(0, 2)));
      else
        axi_read(int'($urandom_range(0, MS - 1)), int'($urandom_range(0, 2)), d);
    end

    // Reset during fetch: no response, contents preserved.
    @(negedge ACLK);
    S_AXI_ARADDR  = AW'(40);
    S_AXI_ARVALID = 1'b1;
    S_AXI_RREADY  = 1'b1;
    @(negedge ACLK);
    S_AXI_ARVALID = 1'b0;
    ARESETN = 1'b0;
    #1;
    check_reset_outputs("fetch_rst");
    repeat (2) @(negedge ACLK);
    ARESETN = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge ACLK);
      check("fetch_rst_no_rvalid", 32'(S_AXI_RVALID), 32'd0);
    end
    check("fetch_rst_arready", 32'(S_AXI_ARREADY), 32'd1);
    axi_read(40, 0, d);
    axi_read(HALF + 40, 0, d);

    // Reset while a response is pending: accepted write stays committed.
    new_word = $urandom;
    @(negedge ACLK);
    S_AXI_AWADDR  = AW'(50);
    S_AXI_WDATA   = new_word;
    S_AXI_WSTRB   = 4'hF;
    S_AXI_AWVALID = 1'b1;
    S_AXI_WVALID  = 1'b1;
    S_AXI_BREADY  = 1'b0;
    @(negedge ACLK);
    S_AXI_AWVALID = 1'b0;
    S_AXI_WVALID  = 1'b0;
    model_write(50, new_word, 4'hF);
    check("wresp_rst_bvalid_pre", 32'(S_AXI_BVALID), 32'd1);
    ARESETN = 1'b0;
    #1;
    check("wresp_rst_bvalid", 32'(S_AXI_BVALID), 32'd0);
    repeat (2) @(negedge ACLK);
    ARESETN = 1'b1;
    S_AXI_BREADY = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge ACLK);
      check("wresp_rst_no_bvalid", 32'(S_AXI_BVALID), 32'd0);
    end
    axi_read(50, 0, d);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
